// File: rtl/elevator_shaft_if.sv
// Controller-to-shaft bus for elevator_shaft: motor/direction/door commands in,
// floor sensors, position and status out.
interface elevator_shaft_if;
    logic       M;
    logic       D;
    logic       P;
    logic       S0;
    logic       S1;
    logic       S2;
    logic [4:0] Pos;
    logic       DoorOpen;
    logic       Moving;
    logic       Fault;

    modport master (
        output M, D, P,
        input  S0, S1, S2, Pos, DoorOpen, Moving, Fault
    );

    modport slave (
        input  M, D, P,
        output S0, S1, S2, Pos, DoorOpen, Moving, Fault
    );
endinterface

// File: rtl/elevator_shaft.sv
// Three-floor elevator shaft model: car position, floor sensors and door FSM with interlock.
// Optional macro SHAFT_FAULT_EN adds a sticky protocol-violation flag on Fault.
module elevator_shaft #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    elevator_shaft_if.slave  bus
);
    typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} door_t;

    localparam logic [4:0] FLOOR1_POS = 5'(TRAVEL_CYCLES);
    localparam logic [4:0] TOP_POS    = 5'(2 * TRAVEL_CYCLES);
    localparam logic [3:0] DOOR_LAST  = 4'(DOOR_CYCLES - 1);

    logic [4:0] r_pos;
    door_t      r_door;
    logic [3:0] r_cnt;
    logic       r_door_open;
    logic       r_moving;

    logic w_at_floor;
    logic w_at_end;
    logic w_step_ok;

    // Sensors decode the position register directly, so they are never late by a cycle.
    assign bus.S0     = (r_pos == 5'd0);
    assign bus.S1     = (r_pos == FLOOR1_POS);
    assign bus.S2     = (r_pos == TOP_POS);
    assign w_at_floor = bus.S0 | bus.S1 | bus.S2;

    assign w_at_end  = bus.D ? (r_pos == TOP_POS) : (r_pos == 5'd0);
    assign w_step_ok = bus.M && (r_door == CLOSED) && !w_at_end;

    // NOTE: reset is sampled on the clock edge only; an async sensitivity would change timing.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_pos       <= 5'd0;
            r_door      <= CLOSED;
            r_cnt       <= 4'd0;
            r_door_open <= 1'b0;
            r_moving    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees the pre-edge state.
            r_moving <= w_step_ok;
            if (w_step_ok) begin
                r_pos <= bus.D ? r_pos + 5'd1 : r_pos - 5'd1;
            end

            case (r_door)
                CLOSED: begin
                    // Motion has priority: the door only starts while the motor is idle.
                    if (bus.P && !bus.M && w_at_floor) begin
                        r_door <= OPENING;
                        r_cnt  <= 4'd0;
                    end
                end
                OPENING: begin
                    if (!bus.P) begin
                        r_door <= CLOSING;
                        r_cnt  <= 4'd0;
                    end else if (r_cnt == DOOR_LAST) begin
                        r_door      <= OPEN;
                        r_door_open <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                OPEN: begin
                    if (!bus.P) begin
                        r_door      <= CLOSING;
                        r_cnt       <= 4'd0;
                        r_door_open <= 1'b0;
                    end
                end
                CLOSING: begin
                    if (bus.P) begin
                        r_door <= OPENING;
                        r_cnt  <= 4'd0;
                    end else if (r_cnt == DOOR_LAST) begin
                        r_door <= CLOSED;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_door <= CLOSED;
                    r_cnt  <= 4'd0;
                end
            endcase
        end
    end

    assign bus.Pos      = r_pos;
    assign bus.DoorOpen = r_door_open;
    assign bus.Moving   = r_moving;

`ifdef SHAFT_FAULT_EN
    logic r_fault;
    logic w_bad_move;

    // Either a drive request against an unclosed door or into an end stop.
    assign w_bad_move = bus.M && ((r_door != CLOSED) || w_at_end);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_fault <= 1'b0;
        end else if (w_bad_move) begin
            r_fault <= 1'b1;
        end
    end

    assign bus.Fault = r_fault;
`else
    assign bus.Fault = 1'b0;
`endif
endmodule

// File: doc/elevator_shaft.md
ELEVATOR_SHAFT -- requirements
Module: elevator_shaft

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 8, clock cycles of motor drive to move between adjacent floors (legal 2..15).
REQ-002 Parameter DOOR_CYCLES, default 4, clock cycles for the door to fully open or fully close (legal 1..15).
REQ-003 Clk  input  1  rising-edge system clock.
REQ-004 Reset  input  1  synchronous, active-low reset; clock Clk.
REQ-005 M  input  1  motor command from the controller (1 = drive).
REQ-006 D  input  1  direction command (1 = up, 0 = down), sampled only when M=1.
REQ-007 P  input  1  door command (1 = open/hold open, 0 = close).
REQ-008 S0, S1, S2  output  1 each  floor sensors; S_k=1 exactly when the car is level with floor k.
REQ-009 Pos  output  5  car position in travel steps, 0 .. 2*TRAVEL_CYCLES.
REQ-010 DoorOpen  output  1  door fully open.
REQ-011 Moving  output  1  a motion step was accepted on the last clock edge.
REQ-012 Fault  output  1  sticky protocol-violation flag (see Configuration).

Function
REQ-013 Floor k SHALL sit at Pos = k*TRAVEL_CYCLES; S0..S2 SHALL be a combinational decode of the Pos register, so at most one is high and all are low between floors.
REQ-014 A motion step SHALL be accepted on an edge when M=1, door state is CLOSED and the move stays in range; Pos increments for D=1, decrements for D=0.
REQ-015 At Pos=0 with D=0, or Pos=2*TRAVEL_CYCLES with D=1, Pos SHALL hold (saturate) and no step is accepted.
REQ-016 Moving SHALL be registered: 1 for the cycle following an accepted step, else 0.
REQ-017 Door FSM states: CLOSED, OPENING, OPEN, CLOSING; a 4-bit door counter times OPENING and CLOSING.
REQ-018 CLOSED -> OPENING when P=1, M=0 and the car is at a floor (any S_k=1); counter cleared.
REQ-019 OPENING: counter increments each cycle; -> OPEN on the edge where counter reaches DOOR_CYCLES-1; P=0 during OPENING -> CLOSING with counter cleared.
REQ-020 OPEN: DoorOpen=1; P=0 -> CLOSING with counter cleared; otherwise hold.
REQ-021 CLOSING: counter increments; -> CLOSED on the edge where counter reaches DOOR_CYCLES-1; P=1 during CLOSING -> OPENING with counter cleared.
REQ-022 DoorOpen SHALL be 1 only in OPEN; M=1 in any non-CLOSED state SHALL NOT move the car (interlock).
REQ-023 Simultaneous P=1 and M=1 in CLOSED: motion wins, door stays CLOSED.

Reset
REQ-024 When Reset=0 at a rising Clk edge: Pos=0 (S0=1, S1=S2=0), door CLOSED, counter 0, DoorOpen=0, Moving=0, Fault=0.
REQ-025 Reset asserted mid-travel or mid-door-cycle SHALL abort the operation and apply REQ-024 on that edge; all inputs are ignored while Reset=0.

Configuration
REQ-026 Macro SHAFT_FAULT_EN defined: Fault SHALL set on the edge after M=1 with door not CLOSED, or M=1 driving into a saturated end (REQ-015), and stay set until reset.
REQ-027 Macro SHAFT_FAULT_EN undefined: Fault SHALL be constant 0 and no fault logic synthesised; interlock and saturation behaviour unchanged.

Verification (TRAVEL_CYCLES=4, DOOR_CYCLES=2)
REQ-028 Reset=0 one edge, then Reset=1, M=0 -> Pos=0, S0=1, S1=S2=0, DoorOpen=0, Fault=0.
REQ-029 M=1, D=1 for 4 edges -> S0 drops after edge 1, Pos=4 and S1=1 after edge 4, Moving=1 for those 4 cycles; 4 more edges -> S2=1, Pos=8.
REQ-030 At floor 1, M=0, P=1 -> DoorOpen=1 after 3 edges (CLOSED->OPENING, 2 counting); P=0 -> DoorOpen=0 next edge, CLOSED 2 edges later.
REQ-031 Door OPEN, M=1, D=1 for 5 edges -> Pos unchanged, Moving=0; with SHAFT_FAULT_EN Fault=1 and remains 1 after M=0; without it Fault=0.
REQ-032 Pos=0, M=1, D=0 -> Pos stays 0, S0=1, Fault per REQ-026/027.
REQ-033 Pos=6, door CLOSED, Reset=0 for one edge -> Pos=0, S0=1, Moving=0, Fault=0.
